// File: rtl/pair_compare_monitor.sv
// Multi-channel comparison monitor: edge-sampled operand pairs, mismatch runs
// filtered to FILT consecutive samples, assert (fail flag) or cover (count) per channel.

module pair_compare_lane #(
   parameter int W        = 8,
   parameter int FILT     = 2,
   parameter int CNT_W    = 8,
   parameter bit IS_COVER = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             s_en,
   input  logic [W-1:0]     s_a,
   input  logic [W-1:0]     s_b,
   output logic             fail_pulse,
   output logic             fail_sticky,
   output logic [CNT_W-1:0] evt_cnt
);
   localparam int RW = $clog2(FILT + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(FILT);
   localparam logic [RW-1:0] RUN_M1  = RW'(FILT - 1);

   logic [RW-1:0]    run_q, run_d;
   logic             pulse_q, pulse_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cond, evt;

   always_comb begin
      cond = s_en && (s_a != s_b);
      // Fires only on the FILT-1 -> FILT transition, so a held run never re-fires.
      evt  = cond && (run_q == RUN_M1) && !clr;

      run_d = run_q;
      if (clr || !cond)
         run_d = '0;
      else if (run_q != RUN_MAX)
         run_d = run_q + 1'b1;

      pulse_d  = evt && !IS_COVER;
      sticky_d = clr ? 1'b0 : (sticky_q || pulse_d);

      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (evt && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q    <= '0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         run_q    <= run_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign fail_pulse  = pulse_q;
   assign fail_sticky = sticky_q;
   assign evt_cnt     = cnt_q;
endmodule

module pair_compare_monitor #(
   parameter int             NCH       = 4,
   parameter int             W         = 8,
   parameter int             FILT      = 2,
   parameter int             CNT_W     = 8,
   parameter logic [NCH-1:0] MODE_MASK = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       en,
   input  logic [NCH*W-1:0]     a,
   input  logic [NCH*W-1:0]     b,
   input  logic                 clr,
   output logic [NCH-1:0]       fail_pulse,
   output logic [NCH-1:0]       fail_sticky,
   output logic [NCH*CNT_W-1:0] evt_cnt,
   output logic                 any_fail
);
   logic [NCH-1:0]        s_en_q, s_en_d;
   logic [NCH-1:0][W-1:0] s_a_q, s_a_d, s_b_q, s_b_d;

   // Stage S is deliberately untouched by clr; only reset empties it.
   always_comb begin
      s_en_d = en;
      s_a_d  = a;
      s_b_d  = b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_en_q <= '0;
         s_a_q  <= '0;
         s_b_q  <= '0;
      end else begin
         s_en_q <= s_en_d;
         s_a_q  <= s_a_d;
         s_b_q  <= s_b_d;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      pair_compare_lane #(
         .W        (W),
         .FILT     (FILT),
         .CNT_W    (CNT_W),
         .IS_COVER (MODE_MASK[i])
      ) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .clr         (clr),
         .s_en        (s_en_q[i]),
         .s_a         (s_a_q[i]),
         .s_b         (s_b_q[i]),
         .fail_pulse  (fail_pulse[i]),
         .fail_sticky (fail_sticky[i]),
         .evt_cnt     (evt_cnt[i*CNT_W +: CNT_W])
      );
   end

   assign any_fail = |fail_sticky;
endmodule

// File: tb/tb_pair_compare_monitor.sv
// Directed bench for pair_compare_monitor: NCH=4, W=8, FILT=2, CNT_W=2, ch3 cover.

module tb_pair_compare_monitor;
   localparam int NCH = 4;
   localparam int W   = 8;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    en;
   logic [NCH*W-1:0]  a, b;
   logic              clr;
   logic [NCH-1:0]    fail_pulse, fail_sticky;
   logic [NCH*CW-1:0] evt_cnt;
   logic              any_fail;

   int checks = 0;
   int errors = 0;

   pair_compare_monitor #(
      .NCH(NCH), .W(W), .FILT(2), .CNT_W(CW), .MODE_MASK(4'b1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .clr(clr),
      .fail_pulse(fail_pulse), .fail_sticky(fail_sticky),
      .evt_cnt(evt_cnt), .any_fail(any_fail)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic all_match();
      a  = '0;
      b  = '0;
      en = '0;
   endtask

   task automatic do_clr();
      all_match();
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         en = 4'($urandom);
         step();
      end
      checks++;
      if ({fail_pulse, fail_sticky, evt_cnt, any_fail} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got pulse=%b sticky=%b cnt=%h any=%b, want all 0",
                  fail_pulse, fail_sticky, evt_cnt, any_fail);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a  = {$urandom, $urandom};
         b  = a;
         en = 4'hF;
         step();
         checks++;
         if ({fail_pulse, fail_sticky, evt_cnt, any_fail} !== '0) begin
            errors++;
            $display("FAIL idle_match cyc%0d: got pulse=%b sticky=%b cnt=%h any=%b, want all 0",
                     i, fail_pulse, fail_sticky, evt_cnt, any_fail);
         end
      end
   endtask

   task automatic test_assert_qual();
      all_match();
      a[0*W +: W] = 8'h55;
      b[0*W +: W] = 8'hAA;
      en[0]       = 1'b1;
      step();  // sample captured
      step();  // run = 1
      checks++;
      if (fail_pulse !== 4'b0000 || evt_cnt !== '0) begin
         errors++;
         $display("FAIL assert_early: got pulse=%b cnt=%h, want 0000 / 0", fail_pulse, evt_cnt);
      end
      step();  // run = 2, qualified
      checks++;
      if (fail_pulse !== 4'b0001) begin
         errors++;
         $display("FAIL assert_pulse: got %b want 0001", fail_pulse);
      end
      checks++;
      if (fail_sticky !== 4'b0001 || any_fail !== 1'b1 || evt_cnt[0 +: CW] !== 2'd1) begin
         errors++;
         $display("FAIL assert_flags: got sticky=%b any=%b cnt0=%0d, want 0001/1/1",
                  fail_sticky, any_fail, evt_cnt[0 +: CW]);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (fail_pulse !== 4'b0000 || evt_cnt[0 +: CW] !== 2'd1 || fail_sticky !== 4'b0001) begin
            errors++;
            $display("FAIL assert_hold cyc%0d: got pulse=%b cnt0=%0d sticky=%b, want 0000/1/0001",
                     i, fail_pulse, evt_cnt[0 +: CW], fail_sticky);
         end
      end
      do_clr();
      checks++;
      if ({fail_pulse, fail_sticky, evt_cnt, any_fail} !== '0) begin
         errors++;
         $display("FAIL clr_all: got pulse=%b sticky=%b cnt=%h any=%b, want all 0",
                  fail_pulse, fail_sticky, evt_cnt, any_fail);
      end
   endtask

   task automatic test_glitch();
      all_match();
      en[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a[1*W +: W] = 8'h01;
         b[1*W +: W] = 8'h02;
         step();
         a[1*W +: W] = 8'h07;
         b[1*W +: W] = 8'h07;
         step();
         checks++;
         if (fail_pulse !== 4'b0000 || evt_cnt[1*CW +: CW] !== 2'd0) begin
            errors++;
            $display("FAIL glitch_single rep%0d: got pulse=%b cnt1=%0d, want 0000/0",
                     i, fail_pulse, evt_cnt[1*CW +: CW]);
         end
      end
      // Mismatch held throughout, but en drops for one sample mid-run.
      a[1*W +: W] = 8'h3C;
      b[1*W +: W] = 8'hC3;
      step();
      en[1] = 1'b0;
      step();
      en[1] = 1'b1;
      step();
      a[1*W +: W] = 8'h00;
      b[1*W +: W] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (fail_pulse !== 4'b0000 || evt_cnt[1*CW +: CW] !== 2'd0 || fail_sticky !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_en_drop cyc%0d: got pulse=%b cnt1=%0d sticky=%b, want 0000/0/0000",
                     i, fail_pulse, evt_cnt[1*CW +: CW], fail_sticky);
         end
      end
   endtask

   task automatic test_cover_sat();
      logic [CW-1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      all_match();
      en[3] = 1'b1;
      for (int r = 0; r < 5; r++) begin
         a[3*W +: W] = 8'hF0;
         b[3*W +: W] = 8'h0F;
         step();
         step();
         a[3*W +: W] = 8'h00;
         b[3*W +: W] = 8'h00;
         step();  // run reaches 2 here
         checks++;
         if (evt_cnt[3*CW +: CW] !== exp_cnt[r]) begin
            errors++;
            $display("FAIL cover_cnt run%0d: got %0d want %0d", r, evt_cnt[3*CW +: CW], exp_cnt[r]);
         end
         checks++;
         if (fail_sticky !== 4'b0000 || any_fail !== 1'b0 || fail_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL cover_no_fail run%0d: got sticky=%b any=%b pulse=%b, want 0",
                     r, fail_sticky, any_fail, fail_pulse);
         end
      end
      step();
      do_clr();
   endtask

   task automatic test_simul_and_clr();
      all_match();
      en = 4'b0101;
      a[0*W +: W] = 8'h11; b[0*W +: W] = 8'h12;
      a[2*W +: W] = 8'h80; b[2*W +: W] = 8'h00;
      step();
      step();
      step();
      checks++;
      if (fail_pulse !== 4'b0101 || fail_sticky !== 4'b0101) begin
         errors++;
         $display("FAIL simul_pulse: got pulse=%b sticky=%b want 0101/0101", fail_pulse, fail_sticky);
      end
      checks++;
      if (evt_cnt !== 8'b00_01_00_01) begin
         errors++;
         $display("FAIL simul_cnt: got %b want 00010001", evt_cnt);
      end
      all_match();
      step();
      step();
      do_clr();

      // clr lands on the qualifying edge: event must vanish.
      en = 4'b0001;
      a[0*W +: W] = 8'hA5; b[0*W +: W] = 8'h5A;
      step();
      step();
      all_match();
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if ({fail_pulse, fail_sticky, evt_cnt, any_fail} !== '0) begin
         errors++;
         $display("FAIL clr_on_qual: got pulse=%b sticky=%b cnt=%h any=%b, want all 0",
                  fail_pulse, fail_sticky, evt_cnt, any_fail);
      end
      step();
      checks++;
      if (fail_pulse !== 4'b0000 || evt_cnt !== '0) begin
         errors++;
         $display("FAIL clr_after: got pulse=%b cnt=%h want 0", fail_pulse, evt_cnt);
      end
      en = 4'b0001;
      a[0*W +: W] = 8'hA5; b[0*W +: W] = 8'h5A;
      step();
      step();
      step();
      checks++;
      if (fail_pulse !== 4'b0001 || evt_cnt !== 8'd1 || any_fail !== 1'b1) begin
         errors++;
         $display("FAIL rearm_qual: got pulse=%b cnt=%h any=%b want 0001/01/1",
                  fail_pulse, evt_cnt, any_fail);
      end
   endtask

   task automatic test_reset_midrun();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({fail_pulse, fail_sticky, evt_cnt, any_fail} !== '0) begin
         errors++;
         $display("FAIL reset_midrun: got pulse=%b sticky=%b cnt=%h any=%b, want all 0",
                  fail_pulse, fail_sticky, evt_cnt, any_fail);
      end
   endtask

   initial begin
      all_match();
      rst_n = 1'b0;
      clr   = 1'b0;
      test_reset();
      test_assert_qual();
      test_glitch();
      test_cover_sat();
      test_simul_and_clr();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
